// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter: FSM states,
// read-owner tags and the default memory depth / starvation limit.
package mem_arb_pkg;

    localparam int DEFAULT_DEPTH      = 1000;
    localparam int DEFAULT_STARVE_MAX = 4;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority select between data and fetch ports, with a saturating
// counter that hands the slot to fetch after STARVE_MAX consecutive data wins.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_fetch_first;

    assign w_fetch_first = (r_starve_cnt == CNT_MAX);

    // Data normally wins; a saturated counter flips priority to fetch for one grant.
    assign o_d_gnt  = i_run & i_d_req & ~(i_if_req & w_fetch_first);
    assign o_if_gnt = i_run & i_if_req & (~i_d_req | w_fetch_first);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req || o_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (o_d_gnt && !w_fetch_first) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: the boot loader owns memory until load_done,
// then data and fetch share it; read data is routed back by an owner tag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_req,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_wdata,
    input  logic              i_load_done,
    output logic              o_load_gnt,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_run,
    output logic              o_addr_err
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    arb_state_t        r_state;
    logic              r_run;
    owner_t            r_owner;
    logic              r_rd_oor;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_run;
    logic              w_load_gnt;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_any_gnt;
    logic              w_in_range;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [DATA_W-1:0] w_rd_data;

    assign w_run = (r_state == ST_RUN);

    // The reset term keeps a loader request from writing while reset is held.
    assign w_load_gnt = i_rst_n & (r_state == ST_BOOT) & i_load_req;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (w_run),
        .i_if_req (i_if_req),
        .i_d_req  (i_d_req),
        .o_if_gnt (w_if_gnt),
        .o_d_gnt  (w_d_gnt)
    );

    assign w_any_gnt = w_load_gnt | w_if_gnt | w_d_gnt;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        if (w_load_gnt) begin
            w_sel_addr  = i_load_addr;
            w_sel_we    = 1'b1;
            w_sel_wdata = i_load_wdata;
        end else if (w_if_gnt) begin
            w_sel_addr  = i_if_addr;
        end else if (w_d_gnt) begin
            w_sel_addr  = i_d_addr;
            w_sel_we    = i_d_we;
            w_sel_wdata = i_d_wdata;
        end
    end

    assign w_in_range = (w_sel_addr < ADDR_LIMIT);

    // Out-of-range accesses are still granted but never reach the array.
    assign o_mem_en    = w_any_gnt & w_in_range;
    assign o_mem_we    = o_mem_en & w_sel_we;
    assign o_mem_addr  = w_sel_addr;
    assign o_mem_wdata = w_sel_wdata;

    assign o_load_gnt = w_load_gnt;
    assign o_if_gnt   = w_if_gnt;
    assign o_d_gnt    = w_d_gnt;
    assign o_run      = r_run;
    assign o_addr_err = r_addr_err;

    assign w_rd_data   = r_rd_oor ? '0 : i_mem_rdata;
    assign o_if_rvalid = (r_owner == OWN_IF);
    assign o_d_rvalid  = (r_owner == OWN_D);
    assign o_if_rdata  = o_if_rvalid ? w_rd_data : r_if_rdata;
    assign o_d_rdata   = o_d_rvalid  ? w_rd_data : r_d_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
            r_run   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (i_load_done) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_run   <= 1'b1;
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

    // The owner tag routes next cycle's mem_rdata; holding registers keep rdata stable otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner    <= OWN_NONE;
            r_rd_oor   <= 1'b0;
            r_addr_err <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_gnt) begin
                r_owner <= OWN_IF;
            end else if (w_d_gnt && !i_d_we) begin
                r_owner <= OWN_D;
            end else begin
                r_owner <= OWN_NONE;
            end
            r_rd_oor   <= ~w_in_range;
            r_addr_err <= r_addr_err | (w_any_gnt & ~w_in_range);
            if (o_if_rvalid) begin
                r_if_rdata <= w_rd_data;
            end
            if (o_d_rvalid) begin
                r_d_rdata <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural 1k-word memory, a shadow copy
// of its contents, and a read scoreboard checked one cycle after each grant.
module tb_mem_arbiter;

    typedef struct packed {
        logic        isIf;
        logic [15:0] data;
    } rd_t;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [15:0] load_addr;
    logic [15:0] load_wdata;
    logic        load_done;
    logic        load_gnt;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        run;
    logic        addr_err;

    logic [15:0] ram    [0:1023];
    logic [15:0] shadow [0:1023];
    rd_t         sb[$];
    int          checks;
    int          failures;

    mem_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_req   (load_req),
        .i_load_addr  (load_addr),
        .i_load_wdata (load_wdata),
        .i_load_done  (load_done),
        .o_load_gnt   (load_gnt),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_gnt     (if_gnt),
        .o_if_rvalid  (if_rvalid),
        .o_if_rdata   (if_rdata),
        .i_d_req      (d_req),
        .i_d_we       (d_we),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .o_d_gnt      (d_gnt),
        .o_d_rvalid   (d_rvalid),
        .o_d_rdata    (d_rdata),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_run        (run),
        .o_addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: writes land at the edge, read data appears the cycle after.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic inRange(input logic [15:0] a);
        return a < 16'd1000;
    endfunction

    // Checks one cycle: pending read data, grants and mem_en, then records new reads/writes.
    task automatic checkOutput(input logic expL, input logic expI, input logic expD);
        rd_t e;
        logic expEn;
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.isIf) begin
                chk("if_rvalid", if_rvalid, 1);
                chk("if_rdata", if_rdata, e.data);
                chk("d_rvalid_quiet", d_rvalid, 0);
            end else begin
                chk("d_rvalid", d_rvalid, 1);
                chk("d_rdata", d_rdata, e.data);
                chk("if_rvalid_quiet", if_rvalid, 0);
            end
        end else begin
            chk("if_rvalid_idle", if_rvalid, 0);
            chk("d_rvalid_idle", d_rvalid, 0);
        end
        chk("load_gnt", load_gnt, expL);
        chk("if_gnt", if_gnt, expI);
        chk("d_gnt", d_gnt, expD);
        expEn = (expL & inRange(load_addr)) | (expI & inRange(if_addr)) | (expD & inRange(d_addr));
        chk("mem_en", mem_en, expEn);
        if (expL && inRange(load_addr)) shadow[load_addr[9:0]] = load_wdata;
        if (expI) sb.push_back('{1'b1, inRange(if_addr) ? shadow[if_addr[9:0]] : 16'h0000});
        if (expD) begin
            if (d_we) begin
                if (inRange(d_addr)) shadow[d_addr[9:0]] = d_wdata;
            end else begin
                sb.push_back('{1'b0, inRange(d_addr) ? shadow[d_addr[9:0]] : 16'h0000});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lr, input logic [15:0] la, input logic [15:0] lw,
                                 input logic ld, input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dw, input logic [15:0] da,
                                 input logic [15:0] dd);
        load_req = lr; load_addr = la; load_wdata = lw; load_done = ld;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mem_rdata = 16'h0000;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 16'h0000;
            shadow[i] = 16'h0000;
        end
        rst_n = 1'b0;
        applyStimulus(1, 16'd3, 16'h7777, 0, 1, 16'd3, 1, 0, 16'd3, 16'h0);

        // Reset state, with every requester asserting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_run", run, 0);
        chk("rst_load_gnt", load_gnt, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_mem_en", mem_en, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot: loader owns memory while fetch and data are gated off.
        applyStimulus(1, 16'd5, 16'h1234, 0, 1, 16'd5, 1, 0, 16'd6, 16'h0);
        checkOutput(1, 0, 0);
        chk("boot_run", run, 0);
        applyStimulus(1, 16'd6, 16'hBEEF, 1, 1, 16'd5, 1, 0, 16'd6, 16'h0);
        checkOutput(1, 0, 0);
        chk("run_after_done", run, 1);
        applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 0, 0, 0);
        checkOutput(0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 16'd6, 0, 0, 0, 0);
        checkOutput(0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);
        checkOutput(0, 0, 0);
        chk("if_rdata_hold", if_rdata, 16'hBEEF);

        // Loader is ignored in RUN; address 7 must stay unwritten.
        applyStimulus(1, 16'd7, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);

        // Starvation: both held, expect four data grants then one fetch grant.
        applyStimulus(0, 0, 0, 0, 1, 16'd7, 1, 0, 16'd5, 16'h0);
        for (int i = 0; i < 10; i++) begin
            checkOutput(0, (i % 5) == 4, (i % 5) != 4);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);

        // Write then immediate read of the same word.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 16'd10, 16'h00FF);
        checkOutput(0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'd10, 16'h0);
        checkOutput(0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);

        // Range: first invalid address reads zero and sets the sticky error.
        chk("addr_err_clear", addr_err, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'd1000, 16'h0);
        checkOutput(0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);
        chk("addr_err_set", addr_err, 1);
        repeat (10) checkOutput(0, 0, 0);
        chk("addr_err_sticky", addr_err, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 16'd999, 16'hA5A5);
        checkOutput(0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'd999, 16'h0);
        checkOutput(0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);

        // Reset while a fetch read is in flight.
        applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 0, 0, 0);
        checkOutput(0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midrst_if_rvalid", if_rvalid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_run", run, 0);
        chk("midrst_addr_err", addr_err, 0);
        checkOutput(0, 0, 0);
        applyStimulus(1, 16'd20, 16'h4321, 0, 1, 16'd5, 0, 0, 0, 0);
        checkOutput(1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one 1k-word × 16-bit synchronous memory between the processor's instruction-fetch port, its data port and a boot loader. After reset only the loader may access memory; once loading completes, data and fetch requests are served under fixed priority with a starvation guard for fetch. It sits between the processor core and the memory array and replaces direct dual-ported access.

## Interface
- DATA_W, 16, word width
- ADDR_W, 16, address width
- DEPTH, 1000, valid words; addresses ≥ DEPTH are out of range
- STARVE_MAX, 4, consecutive data grants tolerated while fetch is waiting (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- load_req / load_addr / load_wdata  in  1/ADDR_W/DATA_W  loader write request
- load_done  in  1  one-cycle pulse, ends BOOT
- load_gnt  out  1  loader write accepted this cycle
- if_req / if_addr  in  1/ADDR_W  fetch read request
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid / if_rdata  out  1/DATA_W  fetch read data
- d_req / d_we / d_addr / d_wdata  in  1/1/ADDR_W/DATA_W  data read or write request
- d_gnt  out  1  data accepted this cycle
- d_rvalid / d_rdata  out  1/DATA_W  data read data
- mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  memory command (combinational from the winner)
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read command
- run  out  1  high in RUN
- addr_err  out  1  sticky flag set by any out-of-range access

## Operation
- FSM states: BOOT (reset state) and RUN.
  - BOOT → RUN on load_done.
  - RUN is left only by reset.
- BOOT:
  - load_req is granted every cycle it is asserted.
  - if_gnt and d_gnt stay 0.
- RUN:
  - load_req is ignored and load_gnt stays 0.
  - Priority: data over fetch, unless the starvation counter equals STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments on each d_gnt while if_req is high.
  - Clears on if_gnt or when if_req is low.
  - Saturates at STARVE_MAX.
- Handshake:
  - A requester holds req and its payload until gnt is high in the same cycle.
  - The gnt cycle is the transfer cycle.
  - Payload changes while req is high and gnt is low are permitted; the payload sampled in the gnt cycle is the one used.
- Reads: the granting cycle registers an owner tag; the next cycle asserts the owner's rvalid for one cycle with rdata = mem_rdata.
- Writes:
  - No rvalid.
  - Memory updates at the granting edge.
  - A read granted the following cycle returns the new value.
- Out-of-range access (addr ≥ DEPTH):
  - Still granted, but mem_en = 0.
  - A read returns rvalid with rdata = 0.
  - A write is dropped.
  - addr_err is set and stays set until reset.
- Idle cycles: mem_en = 0.
- Non-owner rdata holds its last value.

## Timing
- Reset values: state BOOT, run 0, all gnt 0, both rvalid 0, both rdata 0, counter 0, owner tag none, addr_err 0.
- Gnt is combinational from req, state and counter; there is no gnt in the reset cycle.
- Read latency: rvalid exactly 1 cycle after gnt.
  - Back-to-back grants give one rvalid per cycle.
  - A fetch rvalid and a data grant may coincide.
- load_done coinciding with load_req: the load is granted, and RUN starts next cycle.
- Reset asserted mid-read: the pending rvalid is discarded and never appears after reset release.
- if_req and d_req both high in RUN with counter < STARVE_MAX: d_gnt = 1 and if_gnt = 0.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (BOOT, RUN)
  - the owner-tag enum (NONE, IF, D)
  - the default DEPTH and STARVE_MAX constants
- Sub-module mem_arb_prio contains the priority select and the starvation counter.
- The top level contains the FSM, the owner tag, the rdata/rvalid routing, range checking and addr_err.

## Test plan
- Boot: reset, then loader writes 0x1234 @5 and 0xBEEF @6, pulse load_done, fetch @5 and @6 → load_gnt each cycle, run = 1, if_rvalid with 0x1234 then 0xBEEF on consecutive cycles.
- Gating: if_req and d_req high in BOOT → no gnt until after load_done; load_req in RUN → load_gnt stays 0.
- Starvation: STARVE_MAX = 4, d_req and if_req held continuously → pattern of 4 d_gnt, 1 if_gnt, repeating; the fetch wait never exceeds 4 cycles.
- Write-then-read: d write 0x00FF @10, next cycle d read @10 → d_rvalid with 0x00FF; if_rvalid stays 0.
- Range: d read @1000 → d_rvalid with rdata 0, mem_en 0, addr_err = 1 and still 1 after 10 idle cycles; d write @999 is accepted normally.
- Reset mid-read: if_gnt @5 then rst low for 1 cycle → if_rvalid 0, state BOOT, addr_err 0 after release.
